ps2_scan_receiver: RTL

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

---
 rtl/ps2_scan_receiver.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard scancode receiver.
// Both PS/2 lines are synchronised and glitch-filtered. A frame FSM samples
// data on each filtered clock falling edge and checks odd parity and the stop
// bit. E0/F0 prefixes are folded into the ext/make qualifiers of the code
// that follows them. Frames that stall mid-way are abandoned after a timeout.
module ps2_scan_receiver #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 65536
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2Ck,
   input  logic       ps2D,
   output logic       strb,
   output logic       make,
   output logic [7:0] code,
   output logic       ext,
   output logic       err
);

   localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Odd parity holds when data plus parity bit contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   // Line index 0 carries the PS/2 clock, index 1 the PS/2 data.
   logic [1:0]    meta_r;
   logic [1:0]    sync_r;
   logic [1:0]    filt_r;
   logic [FW-1:0] fcnt_r [2];
   logic          ck_hist_r;

   state_t        state_r, state_s;
   logic [2:0]    bit_cnt_r, bit_cnt_s;
   logic [7:0]    shift_r, shift_s;
   logic          par_r, par_s;
   logic          ext_flag_r, ext_flag_s;
   logic          rel_flag_r, rel_flag_s;
   logic [TW-1:0] tmo_r;
   logic          strb_r, strb_s;
   logic          err_r, err_s;
   logic          make_r, make_s;
   logic          ext_r, ext_s;
   logic [7:0]    code_r, code_s;

   logic          fall_s;
   logic          d_s;
   logic          tmo_hit_s;

   assign fall_s    = ck_hist_r & ~filt_r[0];
   assign d_s       = filt_r[1];
   assign tmo_hit_s = (tmo_r == TMO_LAST) && (state_r != ST_IDLE);

   // Two-flop synchronisers and per-line filters; lines idle high.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_r    <= 2'b11;
         sync_r    <= 2'b11;
         filt_r    <= 2'b11;
         ck_hist_r <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            fcnt_r[i] <= {FW{1'b0}};
         end
      end else begin
         meta_r    <= {ps2D, ps2Ck};
         sync_r    <= meta_r;
         ck_hist_r <= filt_r[0];
         for (int i = 0; i < 2; i++) begin
            if (sync_r[i] == filt_r[i]) begin
               fcnt_r[i] <= {FW{1'b0}};
            end else if (fcnt_r[i] == FILT_LAST) begin
               filt_r[i] <= sync_r[i];
               fcnt_r[i] <= {FW{1'b0}};
            end else begin
               fcnt_r[i] <= fcnt_r[i] + {{(FW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Stall timer: cleared by clock edges and in IDLE, saturates at its limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_r <= {TW{1'b0}};
      end else if (fall_s || (state_r == ST_IDLE)) begin
         tmo_r <= {TW{1'b0}};
      end else if (tmo_r != TMO_LAST) begin
         tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         tmo_r <= tmo_r;
      end
   end

   // Frame FSM state and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         par_r      <= 1'b0;
         ext_flag_r <= 1'b0;
         rel_flag_r <= 1'b0;
         strb_r     <= 1'b0;
         err_r      <= 1'b0;
         make_r     <= 1'b0;
         ext_r      <= 1'b0;
         code_r     <= 8'h00;
      end else begin
         state_r    <= state_s;
         bit_cnt_r  <= bit_cnt_s;
         shift_r    <= shift_s;
         par_r      <= par_s;
         ext_flag_r <= ext_flag_s;
         rel_flag_r <= rel_flag_s;
         strb_r     <= strb_s;
         err_r      <= err_s;
         make_r     <= make_s;
         ext_r      <= ext_s;
         code_r     <= code_s;
      end
   end

   // Next-state, bit assembly, frame validation and prefix handling.
   always_comb begin
      state_s    = state_r;
      bit_cnt_s  = bit_cnt_r;
      shift_s    = shift_r;
      par_s      = par_r;
      ext_flag_s = ext_flag_r;
      rel_flag_s = rel_flag_r;
      strb_s     = 1'b0;
      err_s      = 1'b0;
      make_s     = make_r;
      ext_s      = ext_r;
      code_s     = code_r;

      if (tmo_hit_s) begin
         // Stalled frame: drop everything silently.
         state_s    = ST_IDLE;
         bit_cnt_s  = 3'd0;
         shift_s    = 8'h00;
         ext_flag_s = 1'b0;
         rel_flag_s = 1'b0;
      end else if (fall_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!d_s) begin
                  state_s   = ST_DATA;
                  bit_cnt_s = 3'd0;
                  shift_s   = 8'h00;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_s   = {d_s, shift_r[7:1]};
               bit_cnt_s = bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  state_s = ST_PARITY;
               end else begin
                  state_s = ST_DATA;
               end
            end
            ST_PARITY: begin
               par_s   = d_s;
               state_s = ST_STOP;
            end
            ST_STOP: begin
               state_s = ST_IDLE;
               if (odd_parity_ok(shift_r, par_r) && d_s) begin
                  if (shift_r == 8'hE0) begin
                     ext_flag_s = 1'b1;
                  end else if (shift_r == 8'hF0) begin
                     rel_flag_s = 1'b1;
                  end else begin
                     strb_s     = 1'b1;
                     code_s     = shift_r;
                     make_s     = ~rel_flag_r;
                     ext_s      = ext_flag_r;
                     ext_flag_s = 1'b0;
                     rel_flag_s = 1'b0;
                  end
               end else begin
                  err_s      = 1'b1;
                  ext_flag_s = 1'b0;
                  rel_flag_s = 1'b0;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   assign strb = strb_r;
   assign err  = err_r;
   assign make = make_r;
   assign ext  = ext_r;
   assign code = code_r;

endmodule
